dll_train_ctrl: RTL and testbench

DLL_TRAIN_CTRL -- requirements
Module: dll_train_ctrl

---
 rtl/dll_train_pkg.sv | 28 ++
 rtl/dll_win_track.sv | 72 +++++++
 rtl/dll_train_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dll_train_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_train_pkg.sv
// Shared types and defaults for the DLL training controller.
package dll_train_pkg;

    localparam int unsigned ADJ_W            = 8;
    localparam int unsigned DEF_DW           = 1;
    localparam int unsigned DEF_RST_CYCLES   = 16;
    localparam int unsigned DEF_SETTLE       = 4;
    localparam int unsigned DEF_LOCK_TIMEOUT = 1024;
    localparam int unsigned DEF_SAMPLES      = 32;

    typedef logic [ADJ_W-1:0] adj_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_SET,
        S_WAIT_LOCK,
        S_SAMPLE,
        S_NEXT,
        S_FINISH
    } state_t;

    // Centre of a window; always below the step count, so no overflow.
    function automatic adj_t centre(input adj_t start, input adj_t len);
        return adj_t'(start + (len >> 1));
    endfunction

endpackage

// File: rtl/dll_win_track.sv
// Tracks runs of passing adj steps and keeps the earliest longest one.
module dll_win_track
    import dll_train_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_valid,
    input  logic i_pass,
    input  logic i_close,
    input  adj_t i_step,
    output adj_t o_best_len_c,
    output adj_t o_best_adj_c
);

    adj_t r_run_len;
    adj_t r_run_start;
    adj_t r_best_len;
    adj_t r_best_start;

    adj_t w_run_len_n;
    adj_t w_run_start_n;
    adj_t w_cand_len;
    adj_t w_cand_start;
    adj_t w_best_len_n;
    adj_t w_best_start_n;
    logic w_upd;

    // A run is judged against best only when it ends (fail step or close).
    always_comb begin
        w_run_len_n   = r_run_len;
        w_run_start_n = r_run_start;
        if (i_valid) begin
            if (i_pass) begin
                w_run_len_n = adj_t'(r_run_len + 8'd1);
                if (r_run_len == '0) begin
                    w_run_start_n = i_step;
                end
            end else begin
                w_run_len_n = '0;
            end
        end
        w_cand_len     = (i_valid && i_pass) ? w_run_len_n   : r_run_len;
        w_cand_start   = (i_valid && i_pass) ? w_run_start_n : r_run_start;
        w_upd          = (i_close || (i_valid && !i_pass)) && (w_cand_len > r_best_len);
        w_best_len_n   = w_upd ? w_cand_len   : r_best_len;
        w_best_start_n = w_upd ? w_cand_start : r_best_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_len    <= '0;
            r_run_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
        end else if (i_clr) begin
            r_run_len    <= '0;
            r_run_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
        end else begin
            r_run_len    <= i_close ? '0 : w_run_len_n;
            r_run_start  <= w_run_start_n;
            r_best_len   <= w_best_len_n;
            r_best_start <= w_best_start_n;
        end
    end

    assign o_best_len_c = w_best_len_n;
    assign o_best_adj_c = centre(w_best_start_n, w_best_len_n);

endmodule

// File: rtl/dll_train_ctrl.sv
// DLL delay training: sweeps adj 0..N-1, samples the pattern per step and centres on the best window.
module dll_train_ctrl
    import dll_train_pkg::*;
#(
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned SETTLE       = DEF_SETTLE,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned SAMPLES      = DEF_SAMPLES
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             io_start,
    input  logic [ADJ_W-1:0] io_madj,
    input  logic             io_lock,
    input  logic [DW-1:0]    io_data,
    input  logic [DW-1:0]    io_expect,
    output logic             io_dll_reset,
    output logic [ADJ_W-1:0] io_adj,
    output logic             io_busy,
    output logic             io_done,
    output logic             io_pass,
    output logic [ADJ_W-1:0] io_best_adj,
    output logic [ADJ_W-1:0] io_win_len,
    output logic             io_err_timeout
);

    localparam int unsigned M1      = (RST_CYCLES > SAMPLES) ? RST_CYCLES : SAMPLES;
    localparam int unsigned M2      = (M1 > SETTLE) ? M1 : SETTLE;
    localparam int unsigned CNT_MAX = (M2 > LOCK_TIMEOUT) ? M2 : LOCK_TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    adj_t          r_n;
    adj_t          r_step;
    logic          r_step_ok;
    logic          r_dll_reset;
    adj_t          r_adj;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    adj_t          r_best_adj;
    adj_t          r_win_len;
    logic          r_err_timeout;

    logic w_last;
    logic w_samp_ok;
    logic w_lock_ok;
    logic w_lock_tmo;
    logic w_busy_nxt;
    logic w_done_nxt;
    logic w_dll_reset_nxt;
    logic w_trk_clr;
    logic w_trk_valid;
    logic w_trk_close;
    adj_t w_best_len;
    adj_t w_best_adj;

    assign w_last     = (r_step == adj_t'(r_n - 8'd1));
    assign w_samp_ok  = (io_data === io_expect) && io_lock;
    assign w_lock_ok  = (r_cnt > CW'(SETTLE)) && io_lock;
    assign w_lock_tmo = (r_cnt == CW'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (io_start) w_state_nxt = (io_madj == '0) ? S_FINISH : S_DRST;
            S_DRST:      if (r_cnt == CW'(RST_CYCLES - 1)) w_state_nxt = S_SET;
            S_SET:       w_state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (w_lock_ok)       w_state_nxt = S_SAMPLE;
                else if (w_lock_tmo) w_state_nxt = S_FINISH;
            end
            S_SAMPLE:    if (!w_samp_ok || r_cnt == CW'(SAMPLES - 1)) w_state_nxt = S_NEXT;
            S_NEXT:      w_state_nxt = w_last ? S_FINISH : S_SET;
            S_FINISH:    w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_dll_reset_nxt = 1'b0;
        w_trk_clr       = 1'b0;
        w_trk_valid     = 1'b0;
        w_trk_close     = 1'b0;
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_FINISH);
        w_dll_reset_nxt = (w_state_nxt == S_DRST);
        w_trk_clr       = (r_state == S_IDLE) && io_start;
        w_trk_valid     = (r_state == S_NEXT);
        w_trk_close     = (r_state == S_NEXT) && w_last;
    end

    // Counter restarts on every state change; WAIT_LOCK starts at 1 so the SET cycle counts toward timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_n           <= '0;
            r_step        <= '0;
            r_step_ok     <= 1'b0;
            r_dll_reset   <= 1'b1;
            r_adj         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_best_adj    <= '0;
            r_win_len     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_dll_reset <= w_dll_reset_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            if (w_state_nxt != r_state || r_state == S_IDLE) begin
                r_cnt <= (w_state_nxt == S_WAIT_LOCK) ? CW'(1) : '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (io_start) begin
                        r_n           <= io_madj;
                        r_step        <= '0;
                        r_adj         <= '0;
                        r_pass        <= 1'b0;
                        r_best_adj    <= '0;
                        r_win_len     <= '0;
                        r_err_timeout <= 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_state_nxt == S_FINISH) begin
                        r_err_timeout <= 1'b1;
                        r_adj         <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (w_state_nxt == S_NEXT) r_step_ok <= w_samp_ok;
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_pass     <= (w_best_len != '0);
                        r_win_len  <= w_best_len;
                        r_best_adj <= w_best_adj;
                        r_adj      <= (w_best_len != '0) ? w_best_adj : '0;
                    end else begin
                        r_step <= adj_t'(r_step + 8'd1);
                        r_adj  <= adj_t'(r_step + 8'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    dll_win_track u_win_track (
        .clk          (clock),
        .rst_n        (reset_n),
        .i_clr        (w_trk_clr),
        .i_valid      (w_trk_valid),
        .i_pass       (r_step_ok),
        .i_close      (w_trk_close),
        .i_step       (r_step),
        .o_best_len_c (w_best_len),
        .o_best_adj_c (w_best_adj)
    );

    assign io_dll_reset   = r_dll_reset;
    assign io_adj         = r_adj;
    assign io_busy        = r_busy;
    assign io_done        = r_done;
    assign io_pass        = r_pass;
    assign io_best_adj    = r_best_adj;
    assign io_win_len     = r_win_len;
    assign io_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_dll_train_ctrl.sv
// Scoreboarded bench for dll_train_ctrl with a behavioural DLL and window model.
module tb_dll_train_ctrl;

    localparam int unsigned DW     = 1;
    localparam int unsigned RST_C  = 5;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned LTO    = 40;
    localparam int unsigned SMP    = 8;

    typedef struct {
        int pass;
        int len;
        int badj;
        int tmo;
        int adj;
    } exp_t;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          io_start  = 1'b0;
    logic [7:0]    io_madj   = 8'd0;
    logic          io_lock   = 1'b0;
    logic [DW-1:0] io_data   = '0;
    logic [DW-1:0] io_expect = '0;
    logic          io_dll_reset;
    logic [7:0]    io_adj;
    logic          io_busy;
    logic          io_done;
    logic          io_pass;
    logic [7:0]    io_best_adj;
    logic [7:0]    io_win_len;
    logic          io_err_timeout;

    always #5 clock = ~clock;

    dll_train_ctrl #(
        .DW(DW), .RST_CYCLES(RST_C), .SETTLE(SETTLE), .LOCK_TIMEOUT(LTO), .SAMPLES(SMP)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .io_start       (io_start),
        .io_madj        (io_madj),
        .io_lock        (io_lock),
        .io_data        (io_data),
        .io_expect      (io_expect),
        .io_dll_reset   (io_dll_reset),
        .io_adj         (io_adj),
        .io_busy        (io_busy),
        .io_done        (io_done),
        .io_pass        (io_pass),
        .io_best_adj    (io_best_adj),
        .io_win_len     (io_win_len),
        .io_err_timeout (io_err_timeout)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural DLL: lock after lock_dly cycles; failing adj values either corrupt data or drop lock.
    bit   pass_map[256];
    bit   use_drop  = 1'b0;
    bit   noisy     = 1'b0;
    bit   lock_dead = 1'b0;
    int   lock_dly  = 0;
    int   since     = 0;
    logic [7:0] prev_adj = 8'd0;

    always @(negedge clock) begin
        int  mx;
        bit  bad;
        bit  lk;
        if (io_dll_reset || io_adj != prev_adj) since = 0;
        else since = since + 1;
        prev_adj  = io_adj;
        mx        = (lock_dly > int'(SETTLE)) ? lock_dly : int'(SETTLE);
        io_expect = DW'($urandom);
        bad       = 1'b0;
        lk        = !lock_dead && (since >= lock_dly);
        if (!pass_map[io_adj]) begin
            if (use_drop) begin
                if (since >= mx + 4) lk = 1'b0;
            end else begin
                bad = noisy ? (($urandom_range(0, 3) != 0) || since >= mx + 6) : 1'b1;
            end
        end
        io_lock = lk;
        io_data = bad ? ~io_expect : io_expect;
    end

    // Reference: scan the pass map for the earliest longest run of passing steps.
    task automatic push_expect(input int n);
        exp_t e;
        int run, rs, blen, bstart;
        run = 0; rs = 0; blen = 0; bstart = 0;
        if (lock_dead && n > 0) begin
            e.pass = 0; e.len = 0; e.badj = 0; e.tmo = 1; e.adj = 0;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (pass_map[i]) begin
                    if (run == 0) rs = i;
                    run++;
                    if (run > blen) begin
                        blen   = run;
                        bstart = rs;
                    end
                end else begin
                    run = 0;
                end
            end
            e.pass = (blen > 0) ? 1 : 0;
            e.len  = blen;
            e.badj = (blen > 0) ? bstart + blen / 2 : 0;
            e.tmo  = 0;
            e.adj  = e.pass ? e.badj : 0;
        end
        sb.push_back(e);
    endtask

    // Monitor: pop an expectation on every io_done and check the held results the cycle after.
    int   n_done = 0;
    bit   post   = 1'b0;
    exp_t cur;
    exp_t last;

    always @(negedge clock) begin
        if (post) begin
            chk("busy_after_done", io_busy, 0);
            chk("adj_hold", io_adj, last.adj);
            chk("pass_hold", io_pass, last.pass);
            post = 1'b0;
        end
        if (io_done) begin
            n_done++;
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_done: got done=1 expected no pending run (t=%0t)", $time);
            end else begin
                cur = sb.pop_front();
                chk("pass", io_pass, cur.pass);
                chk("win_len", io_win_len, cur.len);
                chk("best_adj", io_best_adj, cur.badj);
                chk("err_timeout", io_err_timeout, cur.tmo);
                chk("adj_at_done", io_adj, cur.adj);
                chk("busy_at_done", io_busy, 1);
                last = cur;
                post = 1'b1;
            end
        end
    end

    task automatic pulse_start(input int n);
        @(negedge clock);
        io_madj  = 8'(n);
        io_start = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
        io_madj  = 8'($urandom);
    endtask

    task automatic run(input int n, input bit poke);
        int d0;
        int cyc;
        d0  = n_done;
        cyc = 0;
        push_expect(n);
        pulse_start(n);
        while (n_done == d0 && cyc < 30000) begin
            @(negedge clock);
            cyc++;
            if (poke && cyc == 37 && io_busy) begin
                io_start = 1'b1;
                io_madj  = 8'($urandom);
                @(negedge clock);
                io_start = 1'b0;
                cyc++;
            end
        end
        if (n_done == d0) begin
            errors++;
            checks++;
            $display("FAIL run_timeout: got no done after %0d cycles expected done (n=%0d)", cyc, n);
            sb.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic set_window(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) pass_map[i] = 1'b1;
    endtask

    task automatic clear_map();
        for (int i = 0; i < 256; i++) pass_map[i] = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_dll_reset"}, io_dll_reset, 1);
        chk({tag, "_adj"}, io_adj, 0);
        chk({tag, "_busy"}, io_busy, 0);
        chk({tag, "_done"}, io_done, 0);
        chk({tag, "_pass"}, io_pass, 0);
        chk({tag, "_best_adj"}, io_best_adj, 0);
        chk({tag, "_win_len"}, io_win_len, 0);
        chk({tag, "_err_timeout"}, io_err_timeout, 0);
    endtask

    initial begin
        int c;
        clear_map();
        #12;
        chk_reset_values("rst");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("dll_reset_release", io_dll_reset, 0);

        // Single window 4..9
        clear_map(); set_window(4, 9);
        use_drop = 0; noisy = 0; lock_dly = 2;
        run(16, 0);

        // Two equal windows: the first wins
        clear_map(); set_window(2, 4); set_window(10, 12);
        noisy = 1; lock_dly = 7;
        run(16, 1);

        // No passing step, then a window reaching the last step via lock drops
        clear_map();
        noisy = 0; lock_dly = 0;
        run(8, 0);
        clear_map(); set_window(5, 7);
        use_drop = 1; lock_dly = 5;
        run(8, 0);
        use_drop = 0;

        // Lock never asserts: DRST length and timeout latency
        clear_map(); set_window(0, 15);
        lock_dead = 1;
        push_expect(16);
        pulse_start(16);
        c = 0;
        while (io_dll_reset && c < 1000) begin
            c++;
            @(negedge clock);
        end
        chk("drst_len", c, RST_C);
        c = 0;
        while (!io_done && c < 5000) begin
            @(negedge clock);
            c++;
        end
        chk("timeout_latency", c, LTO);
        repeat (3) @(negedge clock);
        lock_dead = 0;

        // Reset while sampling step 5 discards everything
        clear_map(); set_window(4, 9);
        lock_dly = 0;
        push_expect(16);
        pulse_start(16);
        c = 0;
        while (io_adj != 8'd5 && c < 5000) begin
            @(negedge clock);
            c++;
        end
        chk("reach_step5", io_adj, 5);
        repeat (SETTLE + 4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk_reset_values("midrst");
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("dll_reset_release2", io_dll_reset, 0);
        clear_map(); set_window(4, 9);
        run(16, 0);

        // N=0 finishes immediately
        push_expect(0);
        pulse_start(0);
        c = 1;
        while (!io_done && c < 10) begin
            @(negedge clock);
            c++;
        end
        checks++;
        if (c > 3 || !io_done) begin
            errors++;
            $display("FAIL n0_latency: got %0d cycles expected at most 3", c);
        end
        repeat (3) @(negedge clock);

        // Boundaries: single step, full 255 steps
        clear_map(); pass_map[0] = 1'b1;
        run(1, 0);
        for (int i = 0; i < 256; i++) pass_map[i] = ($urandom_range(0, 99) < 80);
        noisy = 1;
        run(255, 1);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            int p;
            p = $urandom_range(30, 90);
            for (int i = 0; i < 256; i++) pass_map[i] = ($urandom_range(0, 99) < p);
            use_drop = $urandom_range(0, 1);
            noisy    = $urandom_range(0, 1);
            lock_dly = $urandom_range(0, 10);
            run($urandom_range(1, 40), 1);
        end

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL pending_expect: got %0d left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
